reflet_serial_bus_bridge: RTL and testbench

- UART-driven bus initiator that gives an external host read/write access to the 16-bit Reflet memory map (instruction RAM, data RAM, peripherals) without involving the CPU.
- Receives framed commands on rx, takes ownership of the system bus while the CPU is held, performs one 16-bit access, and replies on tx.
- Sits beside reflet_cpu in the 16-bit controller; the top-level muxes addr/data_out/write_en on bus_own and ANDs !bus_own into cpu_enable.

---
 rtl/reflet_serial_bus_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_reflet_serial_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_serial_bus_bridge.sv
// UART host bridge: framed W/R commands on rx become single 16-bit bus accesses, replies on tx.
// Latency: SETUP + 1 write cycle or SETUP + read_latency cycles, then a 1- or 2-byte reply.
// Backpressure: none on rx; bytes arriving outside IDLE/command states are dropped. The host waits for the reply.
`timescale 1ns/1ps
module reflet_serial_bus_bridge #(
    parameter int clk_freq       = 1000000,
    parameter int baud_rate      = 9600,
    parameter int read_latency   = 1,
    parameter int timeout_cycles = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic        bus_own,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_data_out,
    input  logic [15:0] bus_data_in,
    output logic        bus_write_en,
    output logic        busy
);

    localparam int DIV = clk_freq / baud_rate;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_C   = CW'(DIV / 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(timeout_cycles - 1);
    localparam logic [1:0]    LAT_LAST = 2'(read_latency - 1);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE, S_W_AH, S_W_AL, S_W_DH, S_W_DL, S_R_AH, S_R_AL,
        S_SETUP, S_WRITE, S_READ, S_REPLY
    } state_t;

    state_t state;

    // receiver
    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_active;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_valid;

    // transmitter: up to two frames queued in one 20-bit shifter so bytes go out with no gap
    logic [19:0]   tx_frame;
    logic [4:0]    tx_len;
    logic          tx_load;
    logic [19:0]   tx_shift;
    logic [4:0]    tx_left;
    logic [CW-1:0] tx_cnt;

    // command registers
    logic [15:1]   addr_r;
    logic [7:0]    data_hi;
    logic          is_read;
    logic [TW-1:0] to_cnt;
    logic [1:0]    lat_cnt;

    assign busy = (state != S_IDLE);

    // RX: synchronise, detect start edge, sample each bit at mid-period, drop glitches and framing errors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_sync) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= '0;
                end
            end else begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt <= '0;
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                if (rx_cnt == HALF_C) begin
                    if (rx_bit == 4'd0) begin
                        if (rx_sync) rx_active <= 1'b0;
                    end else if (rx_bit == 4'd9) begin
                        rx_active <= 1'b0;
                        rx_valid  <= rx_sync;
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                    end
                end
            end
        end
    end

    // TX: shift out the loaded frame(s) LSB first, each bit held for exactly DIV cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx       <= 1'b1;
            tx_shift <= '0;
            tx_left  <= '0;
            tx_cnt   <= '0;
        end else if (tx_load) begin
            tx_shift <= tx_frame;
            tx_left  <= tx_len;
            tx_cnt   <= '0;
            tx       <= tx_frame[0];
        end else if (tx_left != 5'd0) begin
            if (tx_cnt == DIV_LAST) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[19:1]};
                tx_left  <= tx_left - 5'd1;
                tx       <= (tx_left == 5'd1) ? 1'b1 : tx_shift[1];
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // Command FSM: collect command bytes, own the bus for one access, queue the reply
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            addr_r       <= '0;
            data_hi      <= '0;
            is_read      <= 1'b0;
            to_cnt       <= '0;
            lat_cnt      <= '0;
            bus_own      <= 1'b0;
            bus_addr     <= '0;
            bus_data_out <= '0;
            bus_write_en <= 1'b0;
            tx_frame     <= '0;
            tx_len       <= '0;
            tx_load      <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (rx_valid) begin
                        if (rx_shift == OP_W) begin
                            state   <= S_W_AH;
                            is_read <= 1'b0;
                        end else if (rx_shift == OP_R) begin
                            state   <= S_R_AH;
                            is_read <= 1'b1;
                        end else begin
                            state    <= S_REPLY;
                            tx_frame <= {10'h3FF, 1'b1, NAK, 1'b0};
                            tx_len   <= 5'd10;
                            tx_load  <= 1'b1;
                        end
                    end
                end
                S_W_AH, S_W_AL, S_W_DH, S_W_DL, S_R_AH, S_R_AL: begin
                    if (rx_valid) begin
                        to_cnt <= '0;
                        case (state)
                            S_W_AH: begin addr_r[15:8] <= rx_shift;      state <= S_W_AL; end
                            S_W_AL: begin addr_r[7:1]  <= rx_shift[7:1]; state <= S_W_DH; end
                            S_W_DH: begin data_hi      <= rx_shift;      state <= S_W_DL; end
                            S_W_DL: begin
                                state        <= S_SETUP;
                                bus_own      <= 1'b1;
                                bus_addr     <= {addr_r, 1'b0};
                                bus_data_out <= {data_hi, rx_shift};
                            end
                            S_R_AH: begin addr_r[15:8] <= rx_shift; state <= S_R_AL; end
                            S_R_AL: begin
                                state    <= S_SETUP;
                                bus_own  <= 1'b1;
                                bus_addr <= {addr_r[15:8], rx_shift[7:1], 1'b0};
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (is_read) begin
                        state   <= S_READ;
                        lat_cnt <= '0;
                    end else begin
                        state        <= S_WRITE;
                        bus_write_en <= 1'b1;
                    end
                end
                S_WRITE: begin
                    bus_write_en <= 1'b0;
                    bus_own      <= 1'b0;
                    state        <= S_REPLY;
                    tx_frame     <= {10'h3FF, 1'b1, ACK, 1'b0};
                    tx_len       <= 5'd10;
                    tx_load      <= 1'b1;
                end
                S_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        bus_own  <= 1'b0;
                        state    <= S_REPLY;
                        tx_frame <= {1'b1, bus_data_in[7:0], 1'b0, 1'b1, bus_data_in[15:8], 1'b0};
                        tx_len   <= 5'd20;
                        tx_load  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_REPLY: begin
                    if (!tx_load && tx_left == 5'd0) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_serial_bus_bridge.sv
// Bench for reflet_serial_bus_bridge: directed and random host commands against a RAM responder.
// Replies are decoded from tx and compared with a word-level memory model.
// The host never overlaps a command with a pending reply.
`timescale 1ns/1ps
module tb_reflet_serial_bus_bridge;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic        bus_own;
    logic [15:0] bus_addr;
    logic [15:0] bus_data_out;
    logic [15:0] bus_data_in = 16'h0;
    logic        bus_write_en;
    logic        busy;

    always #5 clk = ~clk;

    reflet_serial_bus_bridge #(
        .clk_freq(1000000), .baud_rate(100000), .read_latency(1), .timeout_cycles(500)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .bus_own(bus_own),
        .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
        .bus_write_en(bus_write_en), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] init_word(input int idx);
        logic [15:0] i16;
        i16 = 16'(idx);
        if (i16 == 16'h4008) return 16'h1234;
        return 16'(i16 * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // RAM responder, read latency 1
    logic [15:0] ram    [0:32767];
    bit          ram_wr [0:32767];
    always @(posedge clk) begin
        if (bus_write_en) begin
            ram[bus_addr[15:1]]    <= bus_data_out;
            ram_wr[bus_addr[15:1]] <= 1'b1;
        end
        bus_data_in <= ram_wr[bus_addr[15:1]] ? ram[bus_addr[15:1]] : init_word(int'(bus_addr[15:1]));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus activity observer
    int          we_cnt = 0, own_cnt = 0, own_odd = 0, busy_cnt = 0;
    logic [15:0] last_we_addr = 0, last_we_data = 0, last_own_addr = 0;
    always @(negedge clk) begin
        if (bus_write_en) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= bus_addr;
            last_we_data <= bus_data_out;
        end
        if (bus_own) begin
            own_cnt       <= own_cnt + 1;
            last_own_addr <= bus_addr;
            if (bus_addr[0]) own_odd <= own_odd + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // UART decoder on tx
    logic [7:0] rep_dat  [0:255];
    logic       rep_stop [0:255];
    int         rep_cyc  [0:255];
    int         rep_n = 0;
    logic [7:0] mon_b;
    int         mon_st;
    always begin
        @(negedge clk);
        if (tx === 1'b0) begin
            mon_st = cyc;
            repeat (DIV/2) @(negedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                if (rep_n < 256) begin
                    rep_dat[rep_n]  = mon_b;
                    rep_stop[rep_n] = tx;
                    rep_cyc[rep_n]  = mon_st;
                    rep_n = rep_n + 1;
                end
            end
        end
    end

    // word-level model of host-visible memory
    logic [15:0] ref_mem [0:32767];
    bit          ref_wr  [0:32767];

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_wr[a[15:1]] ? ref_mem[a[15:1]] : init_word(int'(a[15:1]));
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = good_stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d, input string tag);
        int base_rep, base_we, base_own, base_odd, ne, k;
        logic [15:0] v;
        logic [7:0] e0, e1;
        base_rep = rep_n; base_we = we_cnt; base_own = own_cnt; base_odd = own_odd;
        e1 = 8'h00;
        send_byte(op, 1'b1);
        if (op == 8'h57) begin
            send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
            send_byte(d[15:8], 1'b1); send_byte(d[7:0], 1'b1);
            ne = 1; e0 = 8'h06;
            ref_mem[a[15:1]] = d; ref_wr[a[15:1]] = 1'b1;
        end else if (op == 8'h52) begin
            send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
            v = ref_read(a);
            ne = 2; e0 = v[15:8]; e1 = v[7:0];
        end else begin
            ne = 1; e0 = 8'h15;
        end
        k = 0;
        while (rep_n < base_rep + ne && k < 3000) begin @(negedge clk); k++; end
        k = 0;
        while (busy && k < 300) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        chk({tag, "_count"}, rep_n - base_rep, ne);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_b0"}, rep_dat[base_rep], e0);
        chk({tag, "_stop0"}, rep_stop[base_rep], 1'b1);
        if (ne == 2) begin
            chk({tag, "_b1"}, rep_dat[base_rep + 1], e1);
            chk({tag, "_gap"}, rep_cyc[base_rep + 1] - rep_cyc[base_rep], 10 * DIV);
        end
        chk({tag, "_we"}, we_cnt - base_we, (op == 8'h57) ? 1 : 0);
        if (op == 8'h57) begin
            chk({tag, "_waddr"}, last_we_addr, {a[15:1], 1'b0});
            chk({tag, "_wdata"}, last_we_data, d);
        end
        if (op == 8'h57 || op == 8'h52) begin
            chk({tag, "_own"}, own_cnt - base_own, 2);
            chk({tag, "_oaddr"}, last_own_addr, {a[15:1], 1'b0});
        end else begin
            chk({tag, "_own"}, own_cnt - base_own, 0);
        end
        chk({tag, "_odd"}, own_odd - base_odd, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rep, b_we, b_own, b_busy;
        logic [7:0]  op;
        logic [15:0] a, d;
        logic [7:0]  last_byte;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_own", bus_own, 1'b0);
        chk("rst_addr", bus_addr, 16'h0);
        chk("rst_dout", bus_data_out, 16'h0);
        chk("rst_we", bus_write_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        run_cmd(8'h52, 16'h8010, 16'h0, "rd");
        run_cmd(8'h57, 16'h8010, 16'hBEEF, "wr");
        run_cmd(8'h41, 16'h0, 16'h0, "nak");

        // framing error: stop bit held low
        b_rep = rep_n; b_busy = busy_cnt;
        send_byte(8'h57, 1'b0);
        repeat (300) @(negedge clk);
        chk("frm_busy", busy_cnt - b_busy, 0);
        chk("frm_rep", rep_n - b_rep, 0);

        // inter-byte timeout
        b_rep = rep_n; b_we = we_cnt; b_own = own_cnt; b_busy = busy_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h80, 1'b1);
        chk("to_busy_hi", busy, 1'b1);
        repeat (600) @(negedge clk);
        chk("to_busy_lo", busy, 1'b0);
        chk("to_was_busy", (busy_cnt - b_busy) > 0, 1'b1);
        chk("to_own", own_cnt - b_own, 0);
        chk("to_we", we_cnt - b_we, 0);
        chk("to_rep", rep_n - b_rep, 0);
        run_cmd(8'h52, 16'h0000, 16'h0, "to_rd");

        run_cmd(8'h52, 16'hFFFF, 16'h0, "odd");
        chk("odd_addr", last_own_addr, 16'hFFFE);

        for (int i = 0; i < 16; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = 16'($urandom);
            d = 16'($urandom);
            if (i % 4 == 3) a = {a[15:8], 8'h10} | 16'h8000;
            if (sel == 0) begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = 8'h00;
            end else if (sel < 5) op = 8'h57;
            else op = 8'h52;
            run_cmd(op, a, d, $sformatf("rnd%0d", i));
        end

        // reset in the middle of the second data byte of a write
        send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'hAB, 1'b1);
        chk("mr_busy_pre", busy, 1'b1);
        last_byte = 8'hCD;
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = last_byte[i];
            repeat (DIV) @(negedge clk);
        end
        rx = last_byte[4];
        repeat (DIV/2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mr_tx", tx, 1'b1);
        chk("mr_own", bus_own, 1'b0);
        chk("mr_addr", bus_addr, 16'h0);
        chk("mr_dout", bus_data_out, 16'h0);
        chk("mr_we", bus_write_en, 1'b0);
        chk("mr_busy", busy, 1'b0);
        for (int i = 5; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            rx = last_byte[i];
        end
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        reset = 1'b1;
        b_rep = rep_n; b_we = we_cnt; b_busy = busy_cnt;
        repeat (400) @(negedge clk);
        chk("mr_post_we", we_cnt - b_we, 0);
        chk("mr_post_busy", busy_cnt - b_busy, 0);
        chk("mr_post_rep", rep_n - b_rep, 0);
        run_cmd(8'h52, 16'h1234, 16'h0, "mr_rd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
